// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between a fetch port and a data port.
// Data accesses win unless MAX_DSTREAK data grants in a row have kept a fetch
// waiting; the MEM_ARB_TIMEOUT_EN macro adds a memory-ack watchdog and a sticky ERR flag.
module mem_port_arbiter #(
  parameter int AW          = 30,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IREQ,
  input  logic [AW-1:0] IADDR,
  output logic          IACK,
  output logic [DW-1:0] IRDATA,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [AW-1:0] DADDR,
  input  logic [DW-1:0] DWDATA,
  output logic          DACK,
  output logic [DW-1:0] DRDATA,
  output logic          MREQ,
  output logic          MRW,
  output logic [AW-1:0] MADDR,
  output logic [DW-1:0] MWDATA,
  input  logic [DW-1:0] MRDATA,
  input  logic          MACK,
  output logic          ERR,
  output logic [1:0]    dbg_state
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);

  if (MAX_DSTREAK < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mem_port_arbiter: MAX_DSTREAK and TIMEOUT must both be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_q,   state_d;
  logic [SW-1:0]   dstreak_q, dstreak_d;
  logic            mreq_q,    mreq_d;
  logic            mrw_q,     mrw_d;
  logic [AW-1:0]   maddr_q,   maddr_d;
  logic [DW-1:0]   mwdata_q,  mwdata_d;
  logic            iack_q,    iack_d;
  logic            dack_q,    dack_d;
  logic [DW-1:0]   irdata_q,  irdata_d;
  logic [DW-1:0]   drdata_q,  drdata_d;
  logic            cap_reached;
  logic            bus_done;
  logic [DW-1:0]   bus_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   wait_q,    wait_d;
  logic            err_q,     err_d;
  logic            timed_out;

  // Expires after TIMEOUT consecutive cycles of MACK low.
  assign timed_out = !MACK && (wait_q == TW'(TIMEOUT - 1));
  assign bus_done  = MACK || timed_out;
  assign bus_rdata = MACK ? MRDATA : '0;
`else
  assign bus_done  = MACK;
  assign bus_rdata = MRDATA;
`endif

  assign cap_reached = (dstreak_q == SW'(MAX_DSTREAK));

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    mreq_d    = mreq_q;
    mrw_d     = mrw_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    iack_d    = 1'b0;
    dack_d    = 1'b0;
    irdata_d  = irdata_q;
    drdata_d  = drdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    wait_d    = wait_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        wait_d = '0;
`endif
        if (DREQ && !(IREQ && cap_reached)) begin
          state_d  = DBUS;
          mreq_d   = 1'b1;
          mrw_d    = DRW;
          maddr_d  = DADDR;
          mwdata_d = DWDATA;
          // This branch is only taken below the cap, so the increment saturates.
          if (IREQ) begin
            dstreak_d = dstreak_q + SW'(1);
          end
        end else if (IREQ) begin
          state_d   = IBUS;
          mreq_d    = 1'b1;
          mrw_d     = 1'b0;
          maddr_d   = IADDR;
          mwdata_d  = '0;
          dstreak_d = '0;
        end
      end
      IBUS, DBUS: begin
        if (bus_done) begin
          mreq_d  = 1'b0;
          state_d = RESP;
          if (state_q == IBUS) begin
            iack_d   = 1'b1;
            irdata_d = bus_rdata;
          end else begin
            dack_d = 1'b1;
            if (!mrw_q) begin
              drdata_d = bus_rdata;
            end
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        if (timed_out) begin
          err_d = 1'b1;
        end else if (!MACK) begin
          wait_d = wait_q + TW'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= '0;
      mreq_q    <= 1'b0;
      mrw_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      iack_q    <= 1'b0;
      dack_q    <= 1'b0;
      irdata_q  <= '0;
      drdata_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      mreq_q    <= mreq_d;
      mrw_q     <= mrw_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      iack_q    <= iack_d;
      dack_q    <= dack_d;
      irdata_q  <= irdata_d;
      drdata_q  <= drdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_q    <= wait_d;
      err_q     <= err_d;
`endif
    end
  end

  assign MREQ      = mreq_q;
  assign MRW       = mrw_q;
  assign MADDR     = maddr_q;
  assign MWDATA    = mwdata_q;
  assign IACK      = iack_q;
  assign DACK      = dack_q;
  assign IRDATA    = irdata_q;
  assign DRDATA    = drdata_q;
  assign dbg_state = state_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign ERR       = err_q;
`else
  assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table of single transfers, random transfers,
// and hand-written reset / priority / starvation / timeout sequences.
module tb_mem_port_arbiter;
  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int MAXD = 4;
  localparam int TMO  = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          IREQ;
  logic [AW-1:0] IADDR;
  logic          IACK;
  logic [DW-1:0] IRDATA;
  logic          DREQ;
  logic          DRW;
  logic [AW-1:0] DADDR;
  logic [DW-1:0] DWDATA;
  logic          DACK;
  logic [DW-1:0] DRDATA;
  logic          MREQ;
  logic          MRW;
  logic [AW-1:0] MADDR;
  logic [DW-1:0] MWDATA;
  logic [DW-1:0] MRDATA = '0;
  logic          MACK = 1'b0;
  logic          ERR;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .IREQ(IREQ), .IADDR(IADDR), .IACK(IACK), .IRDATA(IRDATA),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DACK(DACK), .DRDATA(DRDATA),
    .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA), .MRDATA(MRDATA), .MACK(MACK),
    .ERR(ERR), .dbg_state(dbg_state)
  );

  typedef struct {
    bit            is_d;
    bit            rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    bit            exp_mrw;
    logic [DW-1:0] exp_mwdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  int            mem_lat = 0;
  bit            mem_hang = 1'b0;
  logic [31:0]   mem_arr [256];
  logic [DW-1:0] i_exp_q [$];
  logic [DW-1:0] d_exp_q [$];
  bit            grant_log [$];
  int            iack_cnt = 0;
  int            dack_cnt = 0;
  logic [DW-1:0] i_last = '0;
  logic [DW-1:0] d_last = '0;
  bit            err_exp = 1'b0;
  vec_t          tbl [7];

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    forever begin
      @(negedge CLK);
      if (MREQ === 1'b1) begin
        if (!mem_hang && busy_cnt == mem_lat) begin
          MACK   = 1'b1;
          MRDATA = mem_arr[MADDR[7:0]];
          if (MRW) mem_arr[MADDR[7:0]] = MWDATA;
        end else begin
          MACK   = 1'b0;
          MRDATA = $urandom;
        end
        busy_cnt++;
      end else begin
        MACK     = 1'b0;
        busy_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard / grant monitor ----------------
  initial begin
    logic mreq_prev;
    mreq_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (IACK === 1'b1) begin
        iack_cnt++;
        if (i_exp_q.size() == 0) fail_now("iack_unexpected");
        else check("irdata_sb", IRDATA, i_exp_q.pop_front());
      end
      if (DACK === 1'b1) begin
        dack_cnt++;
        if (d_exp_q.size() == 0) fail_now("dack_unexpected");
        else check("drdata_sb", DRDATA, d_exp_q.pop_front());
      end
      if (MREQ === 1'b1 && !mreq_prev) grant_log.push_back(MRW == 1'b0 && MADDR == IADDR);
      mreq_prev = MREQ;
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+#1 with the arbiter in IDLE; returns at posedge+#1 in IDLE.
  task automatic do_xfer(input vec_t v);
    int c0;
    bit got;
    mem_lat  = v.lat;
    mem_hang = 1'b0;
    if (v.is_d) begin
      DREQ = 1'b1; DRW = v.rw; DADDR = v.addr; DWDATA = v.wdata;
      d_exp_q.push_back(v.exp_rdata);
    end else begin
      IREQ = 1'b1; IADDR = v.addr;
      i_exp_q.push_back(v.exp_rdata);
    end
    c0 = cyc;
    @(posedge CLK); #1;
    check("mreq_rise", MREQ, 1);
    check("maddr", MADDR, v.addr);
    check("mrw", MRW, v.exp_mrw);
    check("mwdata", MWDATA, v.exp_mwdata);
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge CLK);
      if ((v.is_d ? DACK : IACK) === 1'b1) got = 1'b1;
    end
    if (!got) begin
      fail_now("ack_wait");
    end else begin
      check("ack_latency", cyc - c0, v.lat + 2);
      check("mreq_low_at_ack", MREQ, 0);
      check("maddr_hold", MADDR, v.addr);
      check("err", ERR, err_exp);
    end
    @(posedge CLK); #1;
    DREQ = 1'b0;
    IREQ = 1'b0;
    if (v.is_d) begin
      if (!v.rw) d_last = v.exp_rdata;
    end else begin
      i_last = v.exp_rdata;
    end
    check("irdata_hold", IRDATA, i_last);
    check("drdata_hold", DRDATA, d_last);
  endtask

  function automatic vec_t mk(input bit is_d, input bit rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int lat, input logic [DW-1:0] rdata);
    vec_t v;
    v.is_d       = is_d;
    v.rw         = rw;
    v.addr       = addr;
    v.wdata      = wdata;
    v.lat        = lat;
    v.exp_mrw    = is_d & rw;
    v.exp_mwdata = is_d ? wdata : '0;
    v.exp_rdata  = rdata;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t rv;
    int   c0;
    int   dcnt0;
    int   mreq_cycles;
    bit   got;
    bit   d_done;
    bit   i_done;
    int   d_acks;
    int   i_acks;

    RST = 1'b1; IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DRW = 1'b0; DADDR = '0; DWDATA = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = {24'hA50000, i[7:0]};
    mem_arr[8'h10] = 32'h1234_5678;

    tbl[0] = mk(1'b0, 1'b0, 30'h10, 32'h0,         0, 32'h1234_5678); // single fetch
    tbl[1] = mk(1'b1, 1'b1, 30'h20, 32'hCAFE_F00D, 0, 32'h0);         // write, DRDATA held
    tbl[2] = mk(1'b1, 1'b0, 30'h20, 32'h0,         3, 32'hCAFE_F00D); // read back, slow ack
    tbl[3] = mk(1'b0, 1'b0, 30'h21, 32'h0,         1, 32'hA500_0021);
    tbl[4] = mk(1'b1, 1'b1, 30'h21, 32'hDEAD_BEEF, 2, 32'hCAFE_F00D);
    tbl[5] = mk(1'b0, 1'b0, 30'h21, 32'h0,         0, 32'hDEAD_BEEF);
    tbl[6] = mk(1'b1, 1'b0, 30'h05, 32'h0,         5, 32'hA500_0005);

    repeat (3) @(posedge CLK);
    #1;
    check("rst_mreq", MREQ, 0);
    check("rst_iack", IACK, 0);
    check("rst_dack", DACK, 0);
    check("rst_irdata", IRDATA, 0);
    check("rst_drdata", DRDATA, 0);
    check("rst_err", ERR, 0);
    check("rst_state", dbg_state, 0);
    RST = 1'b0;

    for (int i = 0; i < 7; i++) do_xfer(tbl[i]);

    for (int n = 0; n < 6; n++) begin
      rv.is_d       = 1'($urandom_range(0, 1));
      rv.rw         = rv.is_d ? 1'($urandom_range(0, 1)) : 1'b0;
      rv.addr       = 30'(32'h40 + $urandom_range(0, 63));
      rv.wdata      = $urandom;
      rv.lat        = $urandom_range(0, 4);
      rv.exp_mrw    = rv.is_d & rv.rw;
      rv.exp_mwdata = rv.is_d ? rv.wdata : '0;
      rv.exp_rdata  = (rv.is_d && rv.rw) ? d_last : mem_arr[rv.addr[7:0]];
      do_xfer(rv);
    end

    // Reset in the middle of a data read: everything clears, no DACK ever appears.
    mem_hang = 1'b1;
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h33;
    @(posedge CLK); #1;
    check("abort_mreq_up", MREQ, 1);
    @(posedge CLK); #3;
    RST = 1'b1;
    #1;
    check("abort_mreq", MREQ, 0);
    check("abort_maddr", MADDR, 0);
    check("abort_mrw", MRW, 0);
    check("abort_mwdata", MWDATA, 0);
    check("abort_dack", DACK, 0);
    check("abort_iack", IACK, 0);
    check("abort_drdata", DRDATA, 0);
    check("abort_irdata", IRDATA, 0);
    check("abort_state", dbg_state, 0);
    DREQ = 1'b0; d_last = '0; i_last = '0;
    i_exp_q.delete(); d_exp_q.delete();
    @(posedge CLK); #1;
    RST = 1'b0; mem_hang = 1'b0;
    dcnt0 = dack_cnt;
    repeat (5) @(posedge CLK);
    #1;
    check("abort_no_dack", dack_cnt - dcnt0, 0);
    do_xfer(tbl[0]);

    // Simultaneous requests: data first, then the fetch.
    grant_log.delete();
    mem_lat = 0;
    IREQ = 1'b1; IADDR = 30'h10; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h05;
    d_exp_q.push_back(mem_arr[8'h05]);
    i_exp_q.push_back(mem_arr[8'h10]);
    d_done = 1'b0; i_done = 1'b0;
    for (int k = 0; k < 40 && !(d_done && i_done); k++) begin
      @(negedge CLK);
      if (DACK === 1'b1) begin
        d_done = 1'b1;
        check("prio_iack_not_first", i_done, 0);
      end
      if (IACK === 1'b1) i_done = 1'b1;
      @(posedge CLK); #1;
      if (d_done) DREQ = 1'b0;
      if (i_done) IREQ = 1'b0;
    end
    if (!(d_done && i_done)) fail_now("prio_acks");
    check("prio_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("prio_first_is_d", grant_log[0], 0);
      check("prio_second_is_i", grant_log[1], 1);
    end
    d_last = mem_arr[8'h05];
    i_last = mem_arr[8'h10];

    // Both held: MAXD data grants, then a forced fetch, twice.
    grant_log.delete();
    mem_lat = 0;
    IREQ = 1'b1; IADDR = 30'h10; DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h06;
    for (int j = 0; j < 2 * MAXD; j++) d_exp_q.push_back(mem_arr[8'h06]);
    for (int j = 0; j < 2; j++) i_exp_q.push_back(mem_arr[8'h10]);
    d_acks = 0; i_acks = 0;
    for (int k = 0; k < 200 && (DREQ || IREQ); k++) begin
      @(negedge CLK);
      if (DACK === 1'b1) d_acks++;
      if (IACK === 1'b1) i_acks++;
      @(posedge CLK); #1;
      if (d_acks >= 2 * MAXD) DREQ = 1'b0;
      if (i_acks >= 2) IREQ = 1'b0;
    end
    if (DREQ || IREQ) fail_now("streak_acks");
    DREQ = 1'b0; IREQ = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("streak_grants", grant_log.size(), 2 * (MAXD + 1));
    for (int j = 0; j < grant_log.size() && j < 2 * (MAXD + 1); j++)
      check($sformatf("streak_grant_%0d", j), grant_log[j], ((j % (MAXD + 1)) == MAXD));
    d_last = mem_arr[8'h06];

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never acknowledges: watchdog ends the read with zero data and sets ERR.
    mem_hang = 1'b1;
    DREQ = 1'b1; DRW = 1'b0; DADDR = 30'h07;
    d_exp_q.push_back('0);
    c0 = cyc; mreq_cycles = 0; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge CLK);
      if (MREQ === 1'b1) mreq_cycles++;
      if (DACK === 1'b1) got = 1'b1;
    end
    if (!got) fail_now("tmo_dack");
    check("tmo_latency", cyc - c0, TMO + 1);
    check("tmo_mreq_cycles", mreq_cycles, TMO);
    check("tmo_err", ERR, 1);
    @(posedge CLK); #1;
    DREQ = 1'b0; mem_hang = 1'b0; d_last = '0; err_exp = 1'b1;
    do_xfer(tbl[0]);
    RST = 1'b1;
    #1;
    check("tmo_err_cleared", ERR, 0);
    @(posedge CLK); #1;
    RST = 1'b0; err_exp = 1'b0; i_last = '0; d_last = '0;
    do_xfer(tbl[3]);
`else
    check("err_tied_low", ERR, 0);
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("i_queue_drained", i_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
